// File: rtl/ov7670_dvp_source.sv
// OV7670-style DVP transmitter: PCLK = clk_i/2, VSYNC/HREF framing and RGB565 test-pattern bytes.
// Define DVP_SOURCE_LFSR_EN to make pattern 3 a seeded LFSR; without it pattern 3 is black.
module ov7670_dvp_source #(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int H_BLANK        = 144,
  parameter int VSYNC_LINES    = 3,
  parameter int V_BACK         = 17,
  parameter int V_FRONT        = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [1:0]  pattern_sel_i,
  output logic        pixel_clk_cmos_o,
  output logic        vsync_cmos_o,
  output logic        href_cmos_o,
  output logic [7:0]  pixel_data_cmos_o,
  output logic        frame_done_o,
  output logic [15:0] frame_count_o
);
  localparam logic [15:0] LAST_COL     = 16'(ACTIVE_COLUMNS + H_BLANK - 1);
  localparam logic [15:0] LAST_LINE    = 16'(VSYNC_LINES + V_BACK + ACTIVE_ROWS + V_FRONT - 1);
  localparam logic [15:0] VBACK_START  = 16'(VSYNC_LINES);
  localparam logic [15:0] ACT_START    = 16'(VSYNC_LINES + V_BACK);
  localparam logic [15:0] VFRONT_START = 16'(VSYNC_LINES + V_BACK + ACTIVE_ROWS);
  localparam logic [15:0] ACT_COLS     = 16'(ACTIVE_COLUMNS);
  localparam logic [15:0] BAR_W        = 16'(ACTIVE_COLUMNS / 8);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } state_t;

  function automatic state_t state_for_line(input logic [15:0] line);
    state_t st;
    if (line < VBACK_START) begin
      st = VSYNC;
    end else if (line < ACT_START) begin
      st = VBACK;
    end else if (line < VFRONT_START) begin
      st = ACTIVE;
    end else begin
      st = VFRONT;
    end
    return st;
  endfunction

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] color;
    case (idx)
      3'd0:    color = 16'hFFFF;
      3'd1:    color = 16'hFFE0;
      3'd2:    color = 16'h07FF;
      3'd3:    color = 16'h07E0;
      3'd4:    color = 16'hF81F;
      3'd5:    color = 16'hF800;
      3'd6:    color = 16'h001F;
      default: color = 16'h0000;
    endcase
    return color;
  endfunction

  state_t      state_r, state_nxt_s;
  logic        pclk_r, byte_r, vsync_r, href_r, frame_done_r;
  logic [15:0] col_r, line_r, frame_count_r;
  logic [7:0]  data_r;
  logic [1:0]  pattern_r;
  logic [15:0] col_nxt_s, line_nxt_s, row_s, bar_s, word_s, lfsr_word_s;
  logic        byte_nxt_s, start_s, frame_end_s, running_nxt_s, last_nxt_s, href_nxt_s;
  logic [7:0]  data_nxt_s;

  // Position of the byte slot that the next PCLK falling edge will present.
  always_comb begin
    col_nxt_s   = 16'd0;
    line_nxt_s  = 16'd0;
    byte_nxt_s  = 1'b0;
    start_s     = 1'b0;
    frame_end_s = (state_r != IDLE) && (line_r == LAST_LINE) && (col_r == LAST_COL) && byte_r;
    if ((state_r == IDLE) || frame_end_s) begin
      start_s = enable_i;
    end else begin
      byte_nxt_s = ~byte_r;
      if (!byte_r) begin
        col_nxt_s  = col_r;
        line_nxt_s = line_r;
      end else if (col_r == LAST_COL) begin
        line_nxt_s = line_r + 16'd1;
      end else begin
        col_nxt_s  = col_r + 16'd1;
        line_nxt_s = line_r;
      end
    end
    running_nxt_s = ((state_r != IDLE) && !frame_end_s) || start_s;
    state_nxt_s   = running_nxt_s ? state_for_line(line_nxt_s) : IDLE;
    last_nxt_s    = running_nxt_s && (line_nxt_s == LAST_LINE) && (col_nxt_s == LAST_COL) && byte_nxt_s;
    href_nxt_s    = (state_nxt_s == ACTIVE) && (col_nxt_s < ACT_COLS);
  end

`ifdef DVP_SOURCE_LFSR_EN
  logic [15:0] lfsr_r;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  // LFSR is reseeded every frame start and steps after the low byte of each active pixel.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr_r <= 16'h0000;
    end else if (pclk_r) begin
      if (start_s) begin
        lfsr_r <= 16'hACE1;
      end else if (href_nxt_s && byte_nxt_s) begin
        lfsr_r <= lfsr_next(lfsr_r);
      end
    end
  end

  assign lfsr_word_s = lfsr_r;
`else
  assign lfsr_word_s = 16'h0000;
`endif

  // Pattern word and byte selection for the upcoming slot.
  always_comb begin
    row_s = line_nxt_s - ACT_START;
    bar_s = col_nxt_s / BAR_W;
    case (pattern_r)
      2'd0:    word_s = col_nxt_s;
      2'd1:    word_s = row_s;
      2'd2:    word_s = bar_color(bar_s[2:0]);
      2'd3:    word_s = lfsr_word_s;
      default: word_s = 16'h0000;
    endcase
    if (href_nxt_s) begin
      data_nxt_s = byte_nxt_s ? word_s[7:0] : word_s[15:8];
    end else begin
      data_nxt_s = 8'h00;
    end
  end

  // Frame FSM, counters and registered DVP outputs; everything but PCLK moves on PCLK falling edges.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pclk_r        <= 1'b0;
      state_r       <= IDLE;
      col_r         <= 16'd0;
      line_r        <= 16'd0;
      byte_r        <= 1'b0;
      pattern_r     <= 2'd0;
      vsync_r       <= 1'b0;
      href_r        <= 1'b0;
      data_r        <= 8'h00;
      frame_done_r  <= 1'b0;
      frame_count_r <= 16'd0;
    end else begin
      pclk_r       <= ~pclk_r;
      frame_done_r <= 1'b0;
      if (pclk_r) begin
        state_r <= state_nxt_s;
        col_r   <= col_nxt_s;
        line_r  <= line_nxt_s;
        byte_r  <= byte_nxt_s;
        vsync_r <= (state_nxt_s == VSYNC);
        href_r  <= href_nxt_s;
        data_r  <= data_nxt_s;
        if (start_s) begin
          pattern_r <= pattern_sel_i;
        end
        if (last_nxt_s) begin
          frame_done_r  <= 1'b1;
          frame_count_r <= frame_count_r + 16'd1;
        end
      end
    end
  end

  assign pixel_clk_cmos_o  = pclk_r;
  assign vsync_cmos_o      = vsync_r;
  assign href_cmos_o       = href_r;
  assign pixel_data_cmos_o = data_r;
  assign frame_done_o      = frame_done_r;
  assign frame_count_o     = frame_count_r;
endmodule

// File: tb/tb_ov7670_dvp_source.sv
// Bench for ov7670_dvp_source: time-based frame model checked every clk, plus directed scenarios.
// Honours DVP_SOURCE_LFSR_EN for the pattern-3 expectations.
module tb_ov7670_dvp_source;
  localparam int AC = 8, AR = 4, HB = 4, VS = 1, VB = 1, VF = 1;
  localparam int LINE_SLOTS = 2 * (AC + HB);
  localparam int TOTAL_LINES = VS + VB + AR + VF;
  localparam int FRAME_CLK = TOTAL_LINES * LINE_SLOTS * 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        pclk, vsync, href, frame_done;
  logic [7:0]  data;
  logic [15:0] frame_count;

  ov7670_dvp_source #(
    .ACTIVE_COLUMNS(AC), .ACTIVE_ROWS(AR), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk_i(clk), .reset_i(rst), .enable_i(enable), .pattern_sel_i(pattern_sel),
    .pixel_clk_cmos_o(pclk), .vsync_cmos_o(vsync), .href_cmos_o(href),
    .pixel_data_cmos_o(data), .frame_done_o(frame_done), .frame_count_o(frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  function automatic logic [15:0] lfsr_after(input int steps);
    logic [15:0] q;
    q = 16'hACE1;
    for (int i = 0; i < steps; i++) q = {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    return q;
  endfunction

  function automatic logic [15:0] exp_word(input int pat, input int c, input int r, input int p);
    case (pat)
      0: return 16'(c);
      1: return 16'(r);
      2: return bars[c / (AC / 8)];
`ifdef DVP_SOURCE_LFSR_EN
      default: return lfsr_after(p);
`else
      default: return 16'h0000;
`endif
    endcase
  endfunction

  // Model: clk edges since reset, frame start edge, latched pattern, completed frames.
  int m_n = 0, m_t0 = 0, m_frames = 0, m_pat = 0, cyc = 0;
  bit m_run = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_n = 0; m_t0 = 0; m_frames = 0; m_pat = 0; m_run = 1'b0;
    end else if (clk) begin
      cyc++;
      m_n++;
      if (m_n % 2 == 0) begin
        if (m_run && (m_n - m_t0 == FRAME_CLK - 2)) m_frames = (m_frames + 1) % 65536;
        if (!m_run || (m_n - m_t0 == FRAME_CLK)) begin
          if (enable) begin
            m_run = 1'b1; m_t0 = m_n; m_pat = int'(pattern_sel);
          end else begin
            m_run = 1'b0;
          end
        end
      end
    end
  end

  logic [7:0] cap[$];
  int vs_rise_cyc[$];
  int href_cycles = 0, href_rises = 0, done_pulses = 0;
  logic prev_href = 1'b0, prev_vsync = 1'b0;

  // Compare process: every falling clk edge, DUT against model; also gathers capture statistics.
  initial forever begin
    int k, line, s, pix, b, row;
    logic ev, eh, ed;
    logic [7:0] edata;
    logic [15:0] w;
    @(negedge clk);
    ev = 1'b0; eh = 1'b0; ed = 1'b0; edata = 8'h00;
    if (m_run) begin
      k = (m_n - m_t0) / 2;
      line = k / LINE_SLOTS; s = k % LINE_SLOTS; pix = s / 2; b = s % 2;
      ev = (line < VS);
      if (line >= VS + VB && line < VS + VB + AR && pix < AC) begin
        eh = 1'b1;
        row = line - VS - VB;
        w = exp_word(m_pat, pix, row, row * AC + pix);
        edata = (b == 1) ? w[7:0] : w[15:8];
      end
      ed = ((m_n - m_t0) == FRAME_CLK - 2);
    end
    check("pclk", pclk, m_n % 2);
    check("vsync", vsync, ev);
    check("href", href, eh);
    check("data", data, edata);
    check("frame_done", frame_done, ed);
    check("frame_count", frame_count, m_frames);
    if (href && !pclk) cap.push_back(data);
    if (href) href_cycles++;
    if (href && !prev_href) href_rises++;
    if (vsync && !prev_vsync) vs_rise_cyc.push_back(cyc);
    if (frame_done) done_pulses++;
    prev_href = href; prev_vsync = vsync;
  end

  task automatic clear_stats();
    cap.delete(); vs_rise_cyc.delete();
    href_cycles = 0; href_rises = 0; done_pulses = 0;
  endtask

  task automatic wait_vsync(input int maxc);
    int i = 0;
    while (!vsync && i < maxc) begin @(negedge clk); i++; end
    check("wait_vsync", vsync, 1'b1);
  endtask

  task automatic wait_done(input int maxc);
    int i = 0;
    while (!frame_done && i < maxc) begin @(negedge clk); i++; end
    check("wait_frame_done", frame_done, 1'b1);
  endtask

  logic [7:0] bar_bytes [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                 8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

  initial begin
    int i;
    int nonzero;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: idle after reset
    repeat (100) @(negedge clk);
    check("s1_vsync", vsync, 1'b0);
    check("s1_href_cycles", href_cycles, 0);
    check("s1_done_pulses", done_pulses, 0);
    check("s1_count", frame_count, 16'd0);

    // 2: pattern 0, one frame
    clear_stats(); pattern_sel = 2'd0; enable = 1'b1;
    wait_vsync(6); enable = 1'b0;
    wait_done(FRAME_CLK + 10);
    check("s2_count", frame_count, 16'd1);
    repeat (10) @(negedge clk);
    check("s2_href_rises", href_rises, 4);
    check("s2_href_cycles", href_cycles, 128);
    check("s2_done_pulses", done_pulses, 1);
    check("s2_bytes", cap.size(), 64);
    if (cap.size() == 64)
      for (int j = 0; j < 64; j++)
        check("s2_byte", cap[j], (j % 2 == 1) ? (j % 16) / 2 : 0);

    // 3: colour bars; a mid-frame pattern change is ignored
    clear_stats(); pattern_sel = 2'd2; enable = 1'b1;
    wait_vsync(6); enable = 1'b0; pattern_sel = 2'd1;
    wait_done(FRAME_CLK + 10);
    repeat (10) @(negedge clk);
    check("s3_count", frame_count, 16'd2);
    check("s3_bytes", cap.size(), 64);
    if (cap.size() == 64)
      for (int j = 0; j < 64; j++) check("s3_bar_byte", cap[j], bar_bytes[j % 16]);

    // 4: enable dropped during row 1
    clear_stats(); pattern_sel = 2'd1; enable = 1'b1;
    wait_vsync(6);
    i = 0;
    while (href_rises < 2 && i < FRAME_CLK) begin @(negedge clk); i++; end
    check("s4_reach_row1", href_rises, 2);
    enable = 1'b0;
    wait_done(FRAME_CLK + 10);
    repeat (40) @(negedge clk);
    check("s4_href_rises", href_rises, 4);
    check("s4_done_pulses", done_pulses, 1);
    check("s4_vsync_rises", vs_rise_cyc.size(), 1);
    check("s4_vsync_idle", vsync, 1'b0);
    check("s4_count", frame_count, 16'd3);
    check("s4_bytes", cap.size(), 64);
    if (cap.size() == 64)
      for (int r = 0; r < 4; r++) check("s4_row_byte", cap[16 * r + 1], r);

    // 5: reset mid-HREF, then restart
    clear_stats(); pattern_sel = 2'd0; enable = 1'b1;
    wait_vsync(6);
    i = 0;
    while (!href && i < FRAME_CLK) begin @(negedge clk); i++; end
    check("s5_href_seen", href, 1'b1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("s5_rst_pclk", pclk, 1'b0);
    check("s5_rst_href", href, 1'b0);
    check("s5_rst_data", data, 8'h00);
    check("s5_rst_vsync", vsync, 1'b0);
    check("s5_rst_done", frame_done, 1'b0);
    check("s5_rst_count", frame_count, 16'd0);
    @(negedge clk);
    clear_stats();
    rst = 1'b0;
    wait_vsync(6); enable = 1'b0;
    wait_done(FRAME_CLK + 10);
    repeat (10) @(negedge clk);
    check("s5_count", frame_count, 16'd1);
    check("s5_bytes", cap.size(), 64);
    if (cap.size() == 64)
      for (int j = 0; j < 16; j++) check("s5_row0_byte", cap[j], (j % 2 == 1) ? j / 2 : 0);

    // 6: pattern 3, two back-to-back frames
    clear_stats(); pattern_sel = 2'd3; enable = 1'b1;
    wait_vsync(6);
    i = 0;
    while (vs_rise_cyc.size() < 2 && i < 2 * FRAME_CLK) begin @(negedge clk); i++; end
    check("s6_second_vsync", vs_rise_cyc.size(), 2);
    enable = 1'b0;
    wait_done(FRAME_CLK + 10);
    repeat (10) @(negedge clk);
    if (vs_rise_cyc.size() == 2) check("s6_frame_len", vs_rise_cyc[1] - vs_rise_cyc[0], 336);
    check("s6_done_pulses", done_pulses, 2);
    check("s6_count", frame_count, 16'd3);
    check("s6_bytes", cap.size(), 128);
    if (cap.size() == 128) begin
`ifdef DVP_SOURCE_LFSR_EN
      for (int f = 0; f < 2; f++) begin
        check("s6_lfsr_b0", cap[64 * f + 0], 8'hAC);
        check("s6_lfsr_b1", cap[64 * f + 1], 8'hE1);
        check("s6_lfsr_b2", cap[64 * f + 2], 8'h59);
        check("s6_lfsr_b3", cap[64 * f + 3], 8'hC3);
      end
`else
      nonzero = 0;
      for (int j = 0; j < 128; j++) if (cap[j] != 8'h00) nonzero++;
      check("s6_black_bytes", nonzero, 0);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ov7670_dvp_source.md
# ov7670_dvp_source

Synthesizable OV7670-style DVP transmitter. It generates pixel clock, VSYNC, HREF and 8-bit RGB565 byte data with deterministic test patterns. The outputs drive the camera-facing inputs of the capture path, either looped back on-chip or in benches, in place of a physical sensor. This gives bit-exact frames for verifying capture, VRAM write and VGA readout.

## Interface
- ACTIVE_COLUMNS, 640, active pixels per line
- ACTIVE_ROWS, 480, active lines per frame
- H_BLANK, 144, blank pixel periods after HREF per line
- VSYNC_LINES, 3, lines with VSYNC high
- V_BACK, 17, blank lines between VSYNC and first active line
- V_FRONT, 10, blank lines after last active line

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- enable_i  in  1  run request, sampled at frame boundaries
- pattern_sel_i  in  2  pattern select, latched at frame start
- pixel_clk_cmos_o  out  1  PCLK, clk_i/2
- vsync_cmos_o  out  1  frame sync, active high
- href_cmos_o  out  1  line valid, active high
- pixel_data_cmos_o  out  8  byte data
- frame_done_o  out  1  one-cycle pulse at end of frame
- frame_count_o  out  16  completed frames, wraps

## Operation
- Byte slot:
  - 2 clk_i cycles.
  - PCLK toggles every clk_i from reset.
  - VSYNC, HREF and data update only on the clk_i edge where PCLK goes 1->0. The receiver samples on PCLK rising.
- Pixel: 2 byte slots, high byte (RRRRRGGG) first, then low byte.
- Line: (ACTIVE_COLUMNS+H_BLANK) pixels. HREF is high for the first 2*ACTIVE_COLUMNS slots of each active line only.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
- IDLE -> VSYNC: at the first PCLK falling edge with enable_i=1.
- VSYNC -> VBACK -> ACTIVE -> VFRONT: after VSYNC_LINES, V_BACK and ACTIVE_ROWS lines respectively.
- VFRONT end:
  - Pulse frame_done_o and increment frame_count_o (mod 2^16).
  - Then go to VSYNC if enable_i=1, else IDLE.
- Deasserting enable_i mid-frame: the frame completes; no truncation.
- pattern_sel_i is latched on VSYNC entry and held for the whole frame. Mid-frame changes are ignored.
- Patterns, 16-bit word for column c, row r:
  - 0: c[15:0]
  - 1: r[15:0]
  - 2: 8 vertical bars, each ACTIVE_COLUMNS/8 wide: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000
  - 3: LFSR (see Configuration)
- Outside HREF, pixel_data_cmos_o is 0x00.
- Counters: column in [0, ACTIVE_COLUMNS+H_BLANK-1]; line in [0, total lines-1]. Both wrap to 0 on terminal count.

## Timing
- Reset values:
  - All outputs 0.
  - FSM IDLE; counters 0; frame_count_o 0.
  - Reset applies immediately, including mid-line; operation restarts from IDLE after release.
- enable_i to VSYNC high: ≤3 clk_i.
- HREF rise:
  - First byte valid on the same edge.
  - Each byte held exactly 2 clk_i.
- Frame length: (VSYNC_LINES+V_BACK+ACTIVE_ROWS+V_FRONT)*(ACTIVE_COLUMNS+H_BLANK)*4 clk_i.
- frame_done_o:
  - High for 1 clk_i, coincident with the final VFRONT slot update edge.
  - frame_count_o updates on the same edge.
- Back-to-back frames: VSYNC rises on the slot immediately after VFRONT ends; zero gap.

## Configuration
- DVP_SOURCE_LFSR_EN defined:
  - Pattern 3 is a 16-bit Fibonacci LFSR, taps 16,14,13,11: next = {q[14:0], q[15]^q[13]^q[12]^q[10]}.
  - Seeded 0xACE1 at each VSYNC entry.
  - Advances once per active pixel.
- DVP_SOURCE_LFSR_EN undefined:
  - Pattern 3 outputs word 0x0000.
  - No LFSR logic is synthesized.

## Test plan
All scenarios use ACTIVE_COLUMNS=8, ACTIVE_ROWS=4, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1.
1. Reset held, then released with enable_i=0 for 100 clk -> VSYNC, HREF, data and frame_done_o stay 0; PCLK toggles every clk.
2. pattern 0, enable for one frame:
   - Each active line bytes are 00,00,00,01,…,00,07.
   - HREF high 32 clk per line, 4 HREF pulses total.
   - Frame is 7*48=336 clk; frame_count_o=1.
3. pattern 2 -> bytes per line: FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00.
4. enable_i dropped during row 1 -> all 4 active lines still output, one frame_done_o pulse, then IDLE with VSYNC low.
5. reset_i asserted mid-HREF -> all outputs 0 in the same cycle; after release with enable_i=1, the next frame starts with VSYNC and row 0 is correct.
6. DVP_SOURCE_LFSR_EN, pattern 3 -> first pixel words 0xACE1, 0x59C3; reseeded identically in the second frame. Without the macro, all bytes are 0x00.
